// File: rtl/pong_pkg.sv
// ----------------------------------------------------------------------------
// pong_pkg
// Shared screen geometry, coordinate types, scheduler state encoding and the
// clamped paddle-move helper used by the paddle scheduler.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package pong_pkg;

  localparam int VS     = 480;  // visible vertical lines
  localparam int HS     = 640;  // visible horizontal pixels
  localparam int HEIGHT = 120;  // paddle height in pixels
  localparam int WIDTH  = 10;   // paddle width in pixels
  localparam int CW     = 10;   // coordinate width

  typedef logic [CW-1:0] coord_t;  // screen coordinate
  typedef logic [CW:0]   wide_t;   // one extra bit so sums/differences never wrap

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAMPLE  = 3'd1,
    S_CALC_P1 = 3'd2,
    S_CALC_P2 = 3'd3,
    S_COMMIT  = 3'd4
  } sched_state_e;

  // Move y by step in the requested direction, clamped to [0, y_max].
  // Down wins when both directions are requested.
  function automatic coord_t move_clamp(input coord_t y, input logic dn,
                                        input logic up, input coord_t step,
                                        input coord_t y_max);
    wide_t  w_sum;
    wide_t  w_diff;
    coord_t res;
    w_sum  = {1'b0, y} + {1'b0, step};
    w_diff = {1'b0, y} - {1'b0, step};
    res    = y;
    if (dn) begin
      res = (w_sum > {1'b0, y_max}) ? y_max : w_sum[CW-1:0];
    end else if (up) begin
      // A borrow out of the extra bit means the move would pass the top edge.
      res = w_diff[CW] ? '0 : w_diff[CW-1:0];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a tick-paced stable counter. The output
// level follows the synchronized input only after it has differed from the
// current level for DEB_CYCLES consecutive ticks.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], i_raw};
  end

  // Count ticks of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync[1] == r_level) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/paddle_move_scheduler.sv
// ----------------------------------------------------------------------------
// paddle_move_scheduler
// Once per frame: snapshot debounced buttons / AI inputs, compute clamped new
// paddle Y for both players, publish them together with a one-cycle strobe.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module paddle_move_scheduler #(
  parameter int VS         = pong_pkg::VS,
  parameter int HEIGHT     = pong_pkg::HEIGHT,
  parameter int STEP       = 10,
  parameter int AI_STEP    = 6,
  parameter int AI_DEAD    = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_frame_tick,
  input  logic             i_freeze,
  input  logic             i_p1_dn_btn,
  input  logic             i_p1_up_btn,
  input  logic             i_p2_dn_btn,
  input  logic             i_p2_up_btn,
  input  logic             i_p2_auto,
  input  pong_pkg::coord_t i_ball_y,
  output pong_pkg::coord_t o_p1_y,
  output pong_pkg::coord_t o_p2_y,
  output logic             o_update_strobe,
  output logic             o_busy
);

  import pong_pkg::*;

  localparam coord_t Y_MAX   = coord_t'(VS - HEIGHT);
  localparam coord_t Y_RESET = coord_t'((VS - HEIGHT) / 2);
  localparam coord_t STEP_C  = coord_t'(STEP);
  localparam coord_t AISTEP  = coord_t'(AI_STEP);
  localparam wide_t  HALF_H  = wide_t'(HEIGHT / 2);
  localparam wide_t  DEAD_W  = wide_t'(AI_DEAD);

  // Button bit order: 0 = P1 down, 1 = P1 up, 2 = P2 down, 3 = P2 up.
  logic [3:0]   w_btn_raw;
  logic [3:0]   w_btn_db;

  sched_state_e r_state;
  sched_state_e w_state_nxt;

  logic [3:0]   r_snap_btn;
  logic         r_snap_auto;
  logic         r_snap_freeze;
  coord_t       r_snap_ball;
  coord_t       r_p1_nxt;
  coord_t       r_p1_y;
  coord_t       r_p2_y;

  wide_t        w_p2_c;
  wide_t        w_ball_w;
  logic         w_ai_dn;
  logic         w_ai_up;
  coord_t       w_p2_nxt;

  assign w_btn_raw = {i_p2_up_btn, i_p2_dn_btn, i_p1_up_btn, i_p1_dn_btn};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tick  (i_frame_tick),
        .i_raw   (w_btn_raw[gi]),
        .o_level (w_btn_db[gi])
      );
    end
  endgenerate

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fixed walk through the per-frame sequence; ticks outside IDLE are dropped.
  always_comb begin
    w_state_nxt     = r_state;
    o_busy          = (r_state != S_IDLE);
    o_update_strobe = (r_state == S_COMMIT);
    case (r_state)
      S_IDLE:    if (i_frame_tick) w_state_nxt = S_SAMPLE;
      S_SAMPLE:  w_state_nxt = S_CALC_P1;
      S_CALC_P1: w_state_nxt = S_CALC_P2;
      S_CALC_P2: w_state_nxt = S_COMMIT;
      S_COMMIT:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Freeze the inputs for this frame so later changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_btn    <= '0;
      r_snap_auto   <= 1'b0;
      r_snap_freeze <= 1'b0;
      r_snap_ball   <= '0;
    end else if (r_state == S_SAMPLE) begin
      r_snap_btn    <= w_btn_db;
      r_snap_auto   <= i_p2_auto;
      r_snap_freeze <= i_freeze;
      r_snap_ball   <= i_ball_y;
    end
  end

  // AI decision and P2 next value from the snapshot and the current P2 position.
  always_comb begin
    w_p2_c   = {1'b0, r_p2_y} + HALF_H;
    w_ball_w = {1'b0, r_snap_ball};
    w_ai_dn  = (w_ball_w > (w_p2_c + DEAD_W));
    w_ai_up  = ((w_ball_w + DEAD_W) < w_p2_c);
    w_p2_nxt = r_p2_y;
    if (r_snap_freeze)
      w_p2_nxt = r_p2_y;
    else if (r_snap_auto)
      w_p2_nxt = move_clamp(r_p2_y, w_ai_dn, w_ai_up, AISTEP, Y_MAX);
    else
      w_p2_nxt = move_clamp(r_p2_y, r_snap_btn[2], r_snap_btn[3], STEP_C, Y_MAX);
  end

  // P1 is computed in CALC_P1; both positions land on entry to COMMIT so the
  // new values and the strobe are visible in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_nxt <= Y_RESET;
      r_p1_y   <= Y_RESET;
      r_p2_y   <= Y_RESET;
    end else begin
      if (r_state == S_CALC_P1)
        r_p1_nxt <= r_snap_freeze ? r_p1_y
                  : move_clamp(r_p1_y, r_snap_btn[0], r_snap_btn[1], STEP_C, Y_MAX);
      if (r_state == S_CALC_P2) begin
        r_p1_y <= r_p1_nxt;
        r_p2_y <= w_p2_nxt;
      end
    end
  end

  assign o_p1_y = r_p1_y;
  assign o_p2_y = r_p2_y;

endmodule

`default_nettype wire

// File: tb/tb_paddle_move_scheduler.sv
// ----------------------------------------------------------------------------
// tb_paddle_move_scheduler
// Directed bench for the paddle scheduler with hand-computed positions.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_paddle_move_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_frame_tick, i_freeze, i_p2_auto;
  logic       i_p1_dn_btn, i_p1_up_btn, i_p2_dn_btn, i_p2_up_btn;
  logic [9:0] i_ball_y;
  logic [9:0] o_p1_y, o_p2_y;
  logic       o_update_strobe, o_busy;

  int n_pass = 0;
  int n_total = 0;
  int stb_total = 0;
  int e;

  always #5 clk = ~clk;

  paddle_move_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_frame_tick    (i_frame_tick),
    .i_freeze        (i_freeze),
    .i_p1_dn_btn     (i_p1_dn_btn),
    .i_p1_up_btn     (i_p1_up_btn),
    .i_p2_dn_btn     (i_p2_dn_btn),
    .i_p2_up_btn     (i_p2_up_btn),
    .i_p2_auto       (i_p2_auto),
    .i_ball_y        (i_ball_y),
    .o_p1_y          (o_p1_y),
    .o_p2_y          (o_p2_y),
    .o_update_strobe (o_update_strobe),
    .o_busy          (o_busy)
  );

  // Running count of strobes seen at clock edges.
  always @(posedge clk) if (o_update_strobe) stb_total++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Change buttons, then let the synchronizers settle before the next tick.
  task automatic set_btn(input logic p1d, input logic p1u, input logic p2d, input logic p2u);
    i_p1_dn_btn = p1d; i_p1_up_btn = p1u; i_p2_dn_btn = p2d; i_p2_up_btn = p2u;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One frame: pulse the tick, optionally re-tick while busy, and check that
  // exactly one strobe arrives, in the 4th cycle after the tick.
  task automatic do_frame(input bit retick);
    int lat, nstb, bsy;
    lat = -1; nstb = 0; bsy = 0;
    i_frame_tick = 1'b1;
    @(posedge clk); #1;
    i_frame_tick = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 1) begin
        bsy = int'(o_busy);
        if (retick) i_frame_tick = 1'b1;
      end
      if (n == 2) i_frame_tick = 1'b0;
      if (o_update_strobe) begin
        nstb++;
        if (lat < 0) lat = n;
      end
      @(posedge clk); #1;
    end
    chk("busy_after_tick", bsy, 1);
    chk("strobe_latency", lat, 4);
    chk("strobe_count", nstb, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    rst_n = 1'b0; i_frame_tick = 1'b0; i_freeze = 1'b0; i_p2_auto = 1'b0;
    i_p1_dn_btn = 1'b0; i_p1_up_btn = 1'b0; i_p2_dn_btn = 1'b0; i_p2_up_btn = 1'b0;
    i_ball_y = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p1_y", o_p1_y, 180);
    chk("rst_p2_y", o_p2_y, 180);
    chk("rst_busy", o_busy, 0);
    chk("rst_strobe", o_update_strobe, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a sequence aborts it without a strobe.
    s0 = stb_total;
    i_frame_tick = 1'b1;
    @(posedge clk); #1;
    i_frame_tick = 1'b0;
    @(posedge clk); #1;
    chk("busy_in_calc", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_p1_y", o_p1_y, 180);
    chk("midrst_p2_y", o_p2_y, 180);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_strobe", stb_total - s0, 0);
    do_frame(0);
    chk("post_rst_p1_y", o_p1_y, 180);
    chk("post_rst_p2_y", o_p2_y, 180);

    // P1 down: accepted on the 16th tick, then 10 per frame.
    set_btn(1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      do_frame(0);
      chk("p1_deb_hold", o_p1_y, 180);
    end
    e = 180;
    for (int i = 16; i <= 20; i++) begin
      do_frame(0);
      e = e + 10;
      chk("p1_down", o_p1_y, e);
    end
    // Freeze holds both paddles but still strobes; a re-tick while busy is ignored.
    i_freeze = 1'b1;
    do_frame(1);
    chk("freeze_p1_y", o_p1_y, 230);
    do_frame(0);
    chk("freeze_p1_y", o_p1_y, 230);
    chk("freeze_p2_y", o_p2_y, 180);
    i_freeze = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      do_frame(0);
      e = (e + 10 > 360) ? 360 : e + 10;
      chk("p1_down_clamp", o_p1_y, e);
    end

    // P1 up from the bottom to the top clamp.
    set_btn(0, 1, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      do_frame(0);
      chk("p1_up_deb_hold", o_p1_y, 360);
    end
    for (int j = 1; j <= 36; j++) begin
      do_frame(0);
      e = (e < 10) ? 0 : e - 10;
      chk("p1_up_clamp", o_p1_y, e);
    end

    // A 10-tick down glitch is not accepted.
    set_btn(1, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      do_frame(0);
      chk("p1_glitch", o_p1_y, 0);
    end
    set_btn(0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      do_frame(0);
      chk("p1_glitch_after", o_p1_y, 0);
    end

    // AI on P2, with both P2 buttons held and debounced: buttons ignored.
    i_p2_auto = 1'b1;
    i_ball_y  = 10'd240;
    set_btn(0, 1, 1, 1);
    for (int i = 1; i <= 17; i++) begin
      do_frame(0);
      chk("ai_btn_ignored", o_p2_y, 180);
    end
    i_ball_y = 10'd300;  // c=240: 300 > 248 -> down 6
    do_frame(0);
    chk("ai_down", o_p2_y, 186);
    i_ball_y = 10'd254;  // c=246: equal to c+dead -> hold
    do_frame(0);
    chk("ai_hold_hi_edge", o_p2_y, 186);
    i_ball_y = 10'd238;  // 238+8 == c -> hold
    do_frame(0);
    chk("ai_hold_lo_edge", o_p2_y, 186);
    i_ball_y = 10'd100;  // far above -> up 6
    do_frame(0);
    chk("ai_up", o_p2_y, 180);

    // Buttons back in charge: both pressed -> down wins.
    i_p2_auto = 1'b0;
    do_frame(0);
    chk("p2_both_dn", o_p2_y, 190);
    do_frame(0);
    chk("p2_both_dn", o_p2_y, 200);

    // Park P2 under AI while the down button's release debounces.
    i_p2_auto = 1'b1;
    i_ball_y  = 10'd260;  // c=260 -> hold
    set_btn(0, 1, 0, 1);
    for (int i = 1; i <= 17; i++) begin
      do_frame(0);
      chk("ai_park", o_p2_y, 200);
    end
    i_ball_y = 10'd100;
    do_frame(0);
    chk("ai_up_off_grid", o_p2_y, 194);

    // Up from 194 in steps of 10 reaches 4, then must clamp to 0, not wrap.
    i_p2_auto = 1'b0;
    e = 194;
    for (int j = 1; j <= 21; j++) begin
      do_frame(0);
      e = (e < 10) ? 0 : e - 10;
      chk("p2_up_clamp", o_p2_y, e);
    end
    chk("p1_final", o_p1_y, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/paddle_move_scheduler.md
Name: paddle_move_scheduler

Overview:
- Sequences paddle position updates for both players: once per video frame it samples debounced buttons, computes clamped new Y positions for P1 and P2, and publishes them with a one-cycle update strobe.
- Sits between board buttons / VGA frame timing and the ball/collision/render logic. It replaces free-running per-clock paddle motion with a frame-paced, bounded datapath.
- P2 is driven by its buttons or by a simple ball-tracking AI, selected by an input.

Parameters:
- VS, 480, visible vertical lines
- HEIGHT, 120, paddle height in pixels
- STEP, 10, pixels moved per frame by a button
- AI_STEP, 6, pixels moved per frame by the AI
- AI_DEAD, 8, AI dead-band around the paddle centre, in pixels
- DEB_CYCLES, 16, consecutive stable samples (one per frame_tick) required to accept a button change

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- freeze  in  1  1 = hold both paddles (serve/pause)
- p1_dn_btn  in  1  P1 move down (Y increases), asynchronous
- p1_up_btn  in  1  P1 move up (Y decreases), asynchronous
- p2_dn_btn  in  1  P2 move down, asynchronous
- p2_up_btn  in  1  P2 move up, asynchronous
- p2_auto  in  1  1 = P2 driven by AI
- ball_y  in  10  ball top Y, used by the AI
- p1_y  out  10  P1 paddle top Y
- p2_y  out  10  P2 paddle top Y
- update_strobe  out  1  one-cycle pulse when p1_y/p2_y have taken new values
- busy  out  1  high while the scheduler is not IDLE

Behaviour:
- Reset (async, active-low): p1_y = p2_y = (VS-HEIGHT)/2 = 180; update_strobe = 0; busy = 0; FSM in IDLE; synchronizers and debounced levels = 0; debounce counters = 0.
- Inputs: each button passes through a 2-FF synchronizer. Debounce counters advance only on frame_tick.
  - A debounced level changes after the synchronized raw value has differed from it for DEB_CYCLES consecutive ticks.
  - The counter clears whenever the raw value matches the debounced level.
- FSM states: IDLE, SAMPLE, CALC_P1, CALC_P2, COMMIT.
  - IDLE -> SAMPLE on frame_tick.
  - SAMPLE: latch the debounced buttons, p2_auto and ball_y into snapshot registers.
  - CALC_P1 computes the P1 next value. CALC_P2 computes the P2 next value.
  - COMMIT: write p1_y/p2_y, pulse update_strobe, go to IDLE.
  - Latency: update_strobe is high in the 4th cycle after the frame_tick cycle. Outputs change in that same cycle.
- frame_tick arriving while busy is ignored; no queueing.
- Move rule (buttons):
  - If dn is pressed: next = min(y+STEP, VS-HEIGHT).
  - Else if up is pressed: next = max(y-STEP, 0).
  - Else: next = y.
  - dn has priority when both are pressed.
  - Compute in 11 bits so there is no underflow or wrap. The result is always in [0, VS-HEIGHT].
- AI rule (p2_auto snapshot = 1): P2 buttons are ignored. Let c = p2_y + HEIGHT/2, in 11 bits.
  - If ball_y > c+AI_DEAD: move down by AI_STEP.
  - If ball_y + AI_DEAD < c: move up by AI_STEP.
  - Otherwise: hold.
  - Apply the same clamping as the button rule.
- freeze sampled high in SAMPLE: both next = current. update_strobe still pulses.
- p2_auto, ball_y or button changes during CALC do not affect the in-progress update.
- Reset asserted mid-sequence: immediate return to reset values. No strobe is produced for the aborted frame.

Decomposition:
- Shared package pong_pkg: VS, HS, HEIGHT, WIDTH constants; FSM state enum type; 10-bit coordinate typedef.
- One sub-module: btn_debounce (2-FF sync + tick-paced stable counter, parameter DEB_CYCLES). Instantiate it 4 times.

Test Plan:
- Reset: assert reset mid-CALC_P1 -> p1_y = p2_y = 180, busy = 0, no strobe. Release reset, then one tick -> strobe 4 cycles later, values unchanged.
- P1 down: hold p1_dn_btn for 16+ ticks, then keep holding -> y steps 180 to 190, 200 ... 360 and stays at 360 (VS-HEIGHT). Never exceeds 360.
- P1 up clamp: start at 4 (force via the sequence above plus up moves), press up -> next = 0, not 1018. Further ticks hold at 0.
- Both buttons pressed on P2 -> moves down by 10 each frame (dn priority). A 10-tick button glitch (< DEB_CYCLES) -> no movement.
- AI: p2_auto = 1, p2_y = 180 (c = 240), ball_y = 300 -> 186. ball_y = 245 -> hold. ball_y = 100 -> 174. P2 buttons have no effect.
- freeze = 1 with p1_dn held -> strobe each frame, p1_y constant. A frame_tick at busy+1 cycle -> ignored (exactly one strobe).
